// File: rtl/conv_pkg.sv
// Shared definitions for the convolution result streamer.
// Holds the MemoryZ geometry, the streamer FSM state type, the FIFO entry
// layout and the result-count helper used when a readout is triggered.
package conv_pkg;

    localparam int DATA_WIDTH_MEMZ = 16;
    localparam int ADDR_WIDTH_MEMZ = 6;
    localparam int SIZE_WIDTH      = 5;
    localparam int KERNEL_SIZE     = 5;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} stream_state_t;

    typedef struct packed {
        logic                       last;
        logic [DATA_WIDTH_MEMZ-1:0] data;
    } z_entry_t;

    // Number of convolution results for an input of length size_y:
    // size_y + KERNEL_SIZE - 1. Fits in the MemoryZ address width (max 35).
    function automatic logic [ADDR_WIDTH_MEMZ-1:0] result_count(
        input logic [SIZE_WIDTH-1:0] size_y
    );
        return ADDR_WIDTH_MEMZ'(size_y) + ADDR_WIDTH_MEMZ'(KERNEL_SIZE - 1);
    endfunction

endpackage

// File: rtl/conv_skid_fifo.sv
// Two-entry FIFO of z_entry_t words sitting between the MemoryZ read return
// and the streamed output.
// Ports:
//   clk, rstn   clock and synchronous active-low reset (empties the FIFO)
//   push        write push_entry this cycle (ignored when full and not popping)
//   push_entry  entry to write
//   pop         remove the head this cycle (ignored when empty)
//   head        current head entry (meaningful only when count != 0)
//   count       number of stored entries, 0..2
module conv_skid_fifo
    import conv_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  z_entry_t   push_entry,
    input  logic       pop,
    output z_entry_t   head,
    output logic [1:0] count
);

    z_entry_t   mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] cnt_q;
    logic       do_push;
    logic       do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && (cnt_q != 2'd0);
    assign do_push = push && ((cnt_q != 2'd2) || do_pop);

    // Storage carries no reset; count and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt_q;

endmodule

// File: rtl/conv_result_streamer.sv
// Reads MemoryZ after the convolution core finishes and streams the results
// out over a valid/ready interface, one 16-bit word per beat.
// Ports:
//   clk, rstn     clock and synchronous active-low reset
//   conv_done     core done; its rising edge starts a readout
//   sizeY         input length of the finished convolution, latched on trigger
//   memZ_addr     MemoryZ read address (holds its value when not reading)
//   memZ_rd_data  MemoryZ read data, valid one cycle after the address
//   zdata, zvalid, zready, zlast   result stream; zlast marks the final beat
//   busy          readout in progress
//   done          one-cycle pulse after the last beat is accepted
module conv_result_streamer
    import conv_pkg::*;
(
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       conv_done,
    input  logic [SIZE_WIDTH-1:0]      sizeY,
    output logic [ADDR_WIDTH_MEMZ-1:0] memZ_addr,
    input  logic [DATA_WIDTH_MEMZ-1:0] memZ_rd_data,
    output logic [DATA_WIDTH_MEMZ-1:0] zdata,
    output logic                       zvalid,
    input  logic                       zready,
    output logic                       zlast,
    output logic                       busy,
    output logic                       done
);

    stream_state_t              state_q;
    stream_state_t              state_d;
    logic                       conv_done_q;
    logic                       trigger;
    logic                       load;
    logic                       issue;
    logic                       credit;
    logic                       pop;
    logic                       rd_last;
    logic [ADDR_WIDTH_MEMZ-1:0] rd_ptr;
    logic [ADDR_WIDTH_MEMZ-1:0] n_q;
    logic                       inflight_p1;
    logic                       last_p1;
    z_entry_t                   push_entry;
    z_entry_t                   head;
    logic [1:0]                 fifo_count;

    // conv_done_q resets high so a level already present at reset release is not an edge.
    assign trigger = conv_done & ~conv_done_q;
    assign pop     = zvalid & zready;
    assign rd_last = (rd_ptr == n_q - ADDR_WIDTH_MEMZ'(1));

    // Credit check counts the beat leaving this cycle as a freed slot; without it a
    // one-cycle read latency into a two-entry FIFO would stall every other cycle.
    assign credit = ({1'b0, fifo_count} + {2'b00, inflight_p1}) < (3'd2 + {2'b00, pop});

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        issue   = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    load    = 1'b1;
                    state_d = (sizeY == '0) ? FIN : READ;
                end
            end
            READ: begin
                busy = 1'b1;
                if (credit) begin
                    issue = 1'b1;
                    if (rd_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && zlast) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // rd_ptr stops at N-1 after the final issue, so memZ_addr never leaves the result range.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            conv_done_q <= 1'b1;
            rd_ptr      <= '0;
            n_q         <= '0;
            inflight_p1 <= 1'b0;
            last_p1     <= 1'b0;
        end else begin
            state_q     <= state_d;
            conv_done_q <= conv_done;
            inflight_p1 <= issue;
            last_p1     <= issue && rd_last;
            if (load) begin
                n_q    <= result_count(sizeY);
                rd_ptr <= '0;
            end else if (issue && !rd_last) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH_MEMZ'(1);
            end
        end
    end

    assign memZ_addr = rd_ptr;

    // ---- read return stage: data registered by MemoryZ joins its last tag ----
    assign push_entry.last = last_p1;
    assign push_entry.data = memZ_rd_data;

    conv_skid_fifo u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (inflight_p1),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count)
    );

    // Head fields are masked so the stream reads as zero whenever nothing is valid.
    assign zvalid = (fifo_count != 2'd0);
    assign zdata  = zvalid ? head.data : '0;
    assign zlast  = zvalid & head.last;

endmodule
